ime_scan_ctrl: RTL and testbench
================================

// Module: ime_scan_ctrl
// PURPOSE
//  Full-search scan sequencer for integer ME. Walks the search window row by row,
//  PE_NUM columns per step, and drives the min-cost selector's controls
//  (rst_mux, cost_v, mvd_x base, mvd_y) aligned to PE-array latency.
//  Sits between the IME top FSM (start/done) and the PE array + min-cost selector.
// PARAMETERS
//  PE_NUM    4  candidates per step (defaults to `PE_NUM); 2*SR_W must be a multiple of it
//  IMVD_LEN  7  signed MV width (defaults to `IMVD_LEN)
//  SR_W      8  horizontal range; x in [-SR_W, SR_W-1]
//  SR_H      4  vertical range;   y in [-SR_H, SR_H-1]
//  PE_LAT    3  cycles from position issue to matching cost at selector input; >=1
// PORTS
//  clk          in   1         clock
//  rst          in   1         synchronous active-high reset
//  start_i      in   1         begin scan of current MB; honoured only in IDLE
//  ref_rdy_i    in   1         reference row data ready; low = issue bubble
//  best_cost_i  in   `SAD4X4_LEN  selector running minimum (IME_EARLY_TERM_EN only)
//  thr_i        in   `SAD4X4_LEN  early-termination threshold (IME_EARLY_TERM_EN only)
//  busy_o       out  1         high in CLR/SCAN/DRAIN
//  row_start_o  out  1         pulse on first issue of each row (PE ref reload)
//  pos_x_o      out  IMVD_LEN  issued x base (to PE array)
//  pos_y_o      out  IMVD_LEN  issued y (to PE array)
//  pos_v_o      out  1         issue valid
//  rst_mux_o    out  1         one-cycle clear of selector minimum
//  cost_v_o     out  1         selector cost_v, delayed issue valid
//  mvd_x_o      out  IMVD_LEN  selector mvd_x base, delayed pos_x
//  mvd_y_o      out  IMVD_LEN  selector mvd_y, delayed pos_y
//  done_o       out  1         one-cycle pulse, all costs delivered
// BEHAVIOUR
//  - Reset: state IDLE, counters cleared, delay line valid bits 0.
//    All outputs 0 after reset; positions are don't-care when their valid is low.
//  - FSM: IDLE -start_i-> CLR (rst_mux_o=1, 1 cycle) -> SCAN.
//    SCAN -last issue-> DRAIN (PE_LAT cycles) -> DONE (done_o=1, 1 cycle) -> IDLE.
//  - SCAN issues only when ref_rdy_i=1.
//    Issue: pos_v_o=1, x starting at -SR_W, stepping +PE_NUM up to SR_W-PE_NUM;
//    then x resets to -SR_W, y+1; y runs -SR_H .. SR_H-1.
//    ref_rdy_i=0: pos_v_o=0 and the counters hold.
//  - Last issue = (x==SR_W-PE_NUM && y==SR_H-1); SCAN->DRAIN on that same cycle's edge.
//  - Delay line: free-running, PE_LAT deep, carries {v,x,y}. Issue at cycle t appears
//    on cost_v_o/mvd_x_o/mvd_y_o at t+PE_LAT. Bubbles propagate as cost_v_o=0.
//  - Arithmetic: two's-complement counters, IMVD_LEN bits, no wrap within legal params.
//  - start_i outside IDLE is ignored.
//  - rst mid-scan aborts: IDLE, delay line flushed. No done_o is generated.
//  - Total issues per MB = (2*SR_W/PE_NUM)*(2*SR_H).
// CONFIGURATION
//  IME_EARLY_TERM_EN defined:
//    - In SCAN, if best_cost_i < thr_i, issuing stops and the FSM goes to DRAIN.
//    - Issues already in flight still reach the selector; done_o follows as normal.
//    - best_cost_i is only sampled on cycles at least PE_LAT+1 cycles after CLR.
//  IME_EARLY_TERM_EN undefined:
//    - best_cost_i and thr_i are unused; the full window is always scanned.
// STRUCTURE
//  - enc_defines.v: PE_NUM, IMVD_LEN, SAD4X4_LEN, IME_SR_W/IME_SR_H defaults,
//    IME_PE_LAT, and the FSM state encodings (IDLE/CLR/SCAN/DRAIN/DONE).
//  - Sub-module ime_scan_dly: parameterised {valid,x,y} shift line
//    (depth PE_LAT, synchronous clear on rst).
// TESTING (PE_NUM=4, SR_W=8, SR_H=4, PE_LAT=3)
//  1. start_i at cycle 0, ref_rdy_i=1 -> rst_mux_o@1; issues @2..33;
//     x order -8,-4,0,4, y -4..3; cost_v_o @5..36; done_o @37 only.
//  2. ref_rdy_i=0 during cycles 10-12 -> counters hold, cost_v_o low @13-15,
//     32 issues still delivered, done_o @40.
//  3. start_i pulsed during SCAN and DRAIN -> ignored; exactly one done_o, 32 cost_v_o.
//  4. rst at cycle 20 mid-scan -> cycle 21 busy_o=0, cost_v_o=0; no done_o;
//     a new start then runs a full 32-issue scan.
//  5. row_start_o high exactly at issues with x=-8 (8 pulses);
//     mvd_y_o steps -4..3 on each row's first cost_v_o.
//  6. IME_EARLY_TERM_EN, thr_i=100, best_cost_i drops to 50 at cycle 12 ->
//     no issue after cycle 12; cost_v_o ends @15; done_o @16.
//     Without the macro: full scan, done_o @37.

Source files
------------

// File: rtl/ime_scan_ctrl_pkg.sv
// Shared defaults and FSM encoding for the integer-ME scan sequencer.
// The early-termination option is selected with IME_EARLY_TERM_EN.
package ime_scan_ctrl_pkg;

  localparam int PE_NUM_DEF   = 4;
  localparam int IMVD_LEN_DEF = 7;
  localparam int SAD4X4_LEN   = 16;
  localparam int IME_SR_W     = 8;
  localparam int IME_SR_H     = 4;
  localparam int IME_PE_LAT   = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_e;

  // Counter width able to hold values 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ime_scan_dly.sv
// Fixed-depth {valid,x,y} shift line aligning issued positions with PE-array costs.
// Valid bits are cleared on rst so an aborted scan leaves no stale costs behind.
module ime_scan_dly #(
  parameter int DEPTH = 3,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         v_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic         v_o,
  output logic [W-1:0] x_o,
  output logic [W-1:0] y_o
);

  logic [DEPTH-1:0]        v_sr;
  logic [DEPTH-1:0][W-1:0] x_sr;
  logic [DEPTH-1:0][W-1:0] y_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_sr <= '0;
      x_sr <= '0;
      y_sr <= '0;
    end else begin
      v_sr[0] <= v_i;
      x_sr[0] <= x_i;
      y_sr[0] <= y_i;
      for (int i = 1; i < DEPTH; i++) begin
        v_sr[i] <= v_sr[i-1];
        x_sr[i] <= x_sr[i-1];
        y_sr[i] <= y_sr[i-1];
      end
    end
  end

  assign v_o = v_sr[DEPTH-1];
  assign x_o = x_sr[DEPTH-1];
  assign y_o = y_sr[DEPTH-1];

endmodule

// File: rtl/ime_scan_ctrl.sv
// Full-search IME scan sequencer: walks the window row by row, PE_NUM columns per step,
// and drives the min-cost selector controls. Optional IME_EARLY_TERM_EN stops on threshold.
module ime_scan_ctrl
  import ime_scan_ctrl_pkg::*;
#(
  parameter int PE_NUM   = PE_NUM_DEF,
  parameter int IMVD_LEN = IMVD_LEN_DEF,
  parameter int SR_W     = IME_SR_W,
  parameter int SR_H     = IME_SR_H,
  parameter int PE_LAT   = IME_PE_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  ref_rdy_i,
  input  logic [SAD4X4_LEN-1:0] best_cost_i,
  input  logic [SAD4X4_LEN-1:0] thr_i,
  output logic                  busy_o,
  output logic                  row_start_o,
  output logic [IMVD_LEN-1:0]   pos_x_o,
  output logic [IMVD_LEN-1:0]   pos_y_o,
  output logic                  pos_v_o,
  output logic                  rst_mux_o,
  output logic                  cost_v_o,
  output logic [IMVD_LEN-1:0]   mvd_x_o,
  output logic [IMVD_LEN-1:0]   mvd_y_o,
  output logic                  done_o
);

  localparam int DW = cnt_w(PE_LAT);
  localparam logic [IMVD_LEN-1:0] X_MIN  = IMVD_LEN'(-SR_W);
  localparam logic [IMVD_LEN-1:0] X_LAST = IMVD_LEN'(SR_W - PE_NUM);
  localparam logic [IMVD_LEN-1:0] X_STEP = IMVD_LEN'(PE_NUM);
  localparam logic [IMVD_LEN-1:0] Y_MIN  = IMVD_LEN'(-SR_H);
  localparam logic [IMVD_LEN-1:0] Y_LAST = IMVD_LEN'(SR_H - 1);
  localparam logic [DW-1:0]       DRAIN_END = DW'(PE_LAT - 1);

  scan_state_e         state_reg, state_next;
  logic [IMVD_LEN-1:0] x_reg, y_reg;
  logic [DW-1:0]       drain_cnt_reg;
  logic                issue, last_issue, et_hit;

  assign issue      = (state_reg == ST_SCAN) && ref_rdy_i;
  assign last_issue = issue && (x_reg == X_LAST) && (y_reg == Y_LAST);

`ifdef IME_EARLY_TERM_EN
  // The selector minimum is meaningless until the first costs of this MB have
  // arrived, so the threshold is ignored until PE_LAT+1 cycles after CLR.
  localparam int AW = $clog2(PE_LAT + 2);
  localparam logic [AW-1:0] AGE_OK = AW'(PE_LAT + 1);
  logic [AW-1:0] age_reg;

  always_ff @(posedge clk) begin
    if (rst)
      age_reg <= '0;
    else if (state_reg == ST_CLR)
      age_reg <= AW'(1);
    else if (age_reg != AGE_OK)
      age_reg <= age_reg + AW'(1);
  end

  assign et_hit = (state_reg == ST_SCAN) && (age_reg == AGE_OK) && (best_cost_i < thr_i);
`else
  logic unused_et;
  assign unused_et = ^{best_cost_i, thr_i};
  assign et_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= (state_reg == ST_DRAIN) ? drain_cnt_reg + DW'(1) : '0;
      if (state_reg == ST_CLR) begin
        x_reg <= X_MIN;
        y_reg <= Y_MIN;
      end else if (issue) begin
        if (x_reg == X_LAST) begin
          x_reg <= X_MIN;
          y_reg <= y_reg + IMVD_LEN'(1);
        end else begin
          x_reg <= x_reg + X_STEP;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_i) state_next = ST_CLR;
      ST_CLR:   state_next = ST_SCAN;
      ST_SCAN:  if (last_issue || et_hit) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt_reg == DRAIN_END) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign busy_o      = (state_reg == ST_CLR) || (state_reg == ST_SCAN) || (state_reg == ST_DRAIN);
  assign rst_mux_o   = (state_reg == ST_CLR);
  assign done_o      = (state_reg == ST_DONE);
  assign pos_v_o     = issue;
  assign pos_x_o     = x_reg;
  assign pos_y_o     = y_reg;
  assign row_start_o = issue && (x_reg == X_MIN);

  ime_scan_dly #(
    .DEPTH (PE_LAT),
    .W     (IMVD_LEN)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .v_i (issue),
    .x_i (x_reg),
    .y_i (y_reg),
    .v_o (cost_v_o),
    .x_o (mvd_x_o),
    .y_o (mvd_y_o)
  );

endmodule

// File: tb/tb_ime_scan_ctrl.sv
// Directed bench for ime_scan_ctrl (PE_NUM=4, SR_W=8, SR_H=4, PE_LAT=3).
// Cycle 0 of each run is the cycle in which start_i is driven high.
module tb_ime_scan_ctrl;
  import ime_scan_ctrl_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start_i, ref_rdy_i;
  logic [SAD4X4_LEN-1:0] best_cost_i, thr_i;
  logic                  busy_o, row_start_o, pos_v_o, rst_mux_o, cost_v_o, done_o;
  logic [6:0]            pos_x_o, pos_y_o, mvd_x_o, mvd_y_o;

  always #5 clk = ~clk;

  ime_scan_ctrl #(.PE_NUM(4), .IMVD_LEN(7), .SR_W(8), .SR_H(4), .PE_LAT(3)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ref_rdy_i(ref_rdy_i),
    .best_cost_i(best_cost_i), .thr_i(thr_i), .busy_o(busy_o),
    .row_start_o(row_start_o), .pos_x_o(pos_x_o), .pos_y_o(pos_y_o),
    .pos_v_o(pos_v_o), .rst_mux_o(rst_mux_o), .cost_v_o(cost_v_o),
    .mvd_x_o(mvd_x_o), .mvd_y_o(mvd_y_o), .done_o(done_o)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int n_iss, first_iss, last_iss, seq_err, n_rs, rs_err;
  int n_cv, first_cv, last_cv, mvd_err, n_row, row_err, gap_cv;
  int n_done, done_cyc, n_rm, rm_cyc, n_busy, busy21, cv21;

  // mode: 1 plain, 2 ref bubbles, 3 stray starts, 4 reset abort, 6 early-term stimulus
  task automatic run(input int mode, input int ncyc);
    int px, py, mx, my;
    n_iss = 0; first_iss = -1; last_iss = -1; seq_err = 0; n_rs = 0; rs_err = 0;
    n_cv = 0; first_cv = -1; last_cv = -1; mvd_err = 0; n_row = 0; row_err = 0; gap_cv = 0;
    n_done = 0; done_cyc = -1; n_rm = 0; rm_cyc = -1; n_busy = 0; busy21 = -1; cv21 = -1;
    for (int c = 0; c < ncyc; c++) begin
      start_i     = (c == 0) || (mode == 3 && (c == 10 || c == 35));
      ref_rdy_i   = !(mode == 2 && c >= 10 && c <= 12);
      rst         = (mode == 4 && c == 20);
      thr_i       = (mode == 6) ? 16'd100 : 16'd0;
      best_cost_i = (mode == 6 && c < 12) ? 16'd200 : 16'd50;
      @(negedge clk);
      px = $signed(pos_x_o); py = $signed(pos_y_o);
      mx = $signed(mvd_x_o); my = $signed(mvd_y_o);
      if (pos_v_o) begin
        if (first_iss < 0) first_iss = c;
        last_iss = c;
        if (px != -8 + 4 * (n_iss % 4) || py != -4 + n_iss / 4) seq_err++;
        n_iss++;
      end
      if (row_start_o) n_rs++;
      if (row_start_o != (pos_v_o && px == -8)) rs_err++;
      if (cost_v_o) begin
        if (first_cv < 0) first_cv = c;
        last_cv = c;
        if (mx != -8 + 4 * (n_cv % 4) || my != -4 + n_cv / 4) mvd_err++;
        if (mx == -8) begin
          if (my != -4 + n_row) row_err++;
          n_row++;
        end
        n_cv++;
        if (c >= 13 && c <= 15) gap_cv++;
      end
      if (done_o) begin n_done++; done_cyc = c; end
      if (rst_mux_o) begin n_rm++; rm_cyc = c; end
      if (busy_o) n_busy++;
      if (c == 21) begin busy21 = int'(busy_o); cv21 = int'(cost_v_o); end
      @(posedge clk); #1;
    end
    rst = 1'b0; start_i = 1'b0; ref_rdy_i = 1'b1;
  endtask

  task automatic chk_full(input string t);
    chk({t, "_rm_cyc"}, rm_cyc, 1);
    chk({t, "_rm_cnt"}, n_rm, 1);
    chk({t, "_iss_first"}, first_iss, 2);
    chk({t, "_iss_cnt"}, n_iss, 32);
    chk({t, "_iss_seq"}, seq_err, 0);
    chk({t, "_cv_cnt"}, n_cv, 32);
    chk({t, "_mvd_seq"}, mvd_err, 0);
    chk({t, "_done_cnt"}, n_done, 1);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; ref_rdy_i = 1'b1; best_cost_i = '0; thr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_pos_v", int'(pos_v_o), 0);
    chk("rst_cost_v", int'(cost_v_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_rst_mux", int'(rst_mux_o), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Full scan with continuous reference data
    run(1, 45);
    chk_full("t1");
    chk("t1_iss_last", last_iss, 33);
    chk("t1_cv_first", first_cv, 5);
    chk("t1_cv_last", last_cv, 36);
    chk("t1_done_cyc", done_cyc, 37);
    chk("t1_busy_cnt", n_busy, 36);
    chk("t1_rs_cnt", n_rs, 8);
    chk("t1_rs_align", rs_err, 0);
    chk("t1_row_cnt", n_row, 8);
    chk("t1_row_y", row_err, 0);

    // Three-cycle reference bubble
    run(2, 45);
    chk_full("t2");
    chk("t2_iss_last", last_iss, 36);
    chk("t2_cv_gap", gap_cv, 0);
    chk("t2_cv_last", last_cv, 39);
    chk("t2_done_cyc", done_cyc, 40);

    // Stray start pulses during SCAN and DRAIN
    run(3, 45);
    chk_full("t3");
    chk("t3_done_cyc", done_cyc, 37);

    // Reset mid-scan aborts without done
    run(4, 40);
    chk("t4_busy21", busy21, 0);
    chk("t4_cv21", cv21, 0);
    chk("t4_done_cnt", n_done, 0);
    chk("t4_iss_last", last_iss, 20);
    run(1, 45);
    chk_full("t4b");
    chk("t4b_done_cyc", done_cyc, 37);

    // Threshold stimulus: stops early only when the option is built in
    run(6, 45);
    chk("t6_iss_seq", seq_err, 0);
    chk("t6_mvd_seq", mvd_err, 0);
    chk("t6_done_cnt", n_done, 1);
`ifdef IME_EARLY_TERM_EN
    chk("t6_iss_last", last_iss, 12);
    chk("t6_iss_cnt", n_iss, 11);
    chk("t6_cv_last", last_cv, 15);
    chk("t6_done_cyc", done_cyc, 16);
`else
    chk("t6_iss_last", last_iss, 33);
    chk("t6_iss_cnt", n_iss, 32);
    chk("t6_cv_last", last_cv, 36);
    chk("t6_done_cyc", done_cyc, 37);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
